// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - control-to-datapath signal bundle for the multi-cycle MIPS core
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    // Controller side: consumes decoded fields and status, drives selects/enables
    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, imm_zext, alu_ctrl, pc_source,
               instr_done, illegal, state
    );

    // Datapath side: supplies decoded fields and status, obeys selects/enables
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, imm_zext, alu_ctrl, pc_source,
               instr_done, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS main control FSM
module mips_multicycle_control (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_control_if.master     bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MADDR   = 4'd2,
        S_MREAD   = 4'd3,
        S_MWB     = 4'd4,
        S_MWRITE  = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JAL     = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_JR      = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    state_t state_q, state_d;

    logic       pc_en_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
    logic [1:0] reg_dst_c, mem_to_reg_c, alu_src_a_c, alu_src_b_c, pc_source_c;
    logic       reg_write_c, imm_zext_c, instr_done_c, illegal_c;
    logic [3:0] alu_ctrl_c;

    // State register; reset always lands in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode (pc_en/ir_write also follow mem_ready/zero)
    always_comb begin
        state_d      = state_q;
        pc_en_c      = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_dst_c    = 2'b00;
        mem_to_reg_c = 2'b00;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        imm_zext_c   = 1'b0;
        alu_ctrl_c   = ALU_AND;
        pc_source_c  = 2'b00;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                alu_ctrl_c  = ALU_ADD;
                ir_write_c  = bus.mem_ready;
                pc_en_c     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b_c = 2'b11;
                alu_ctrl_c  = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE: begin
                        case (bus.funct)
                            FN_ADD, FN_SLT, FN_AND, FN_NOR, FN_SLL: state_d = S_REXEC;
                            FN_JR:                                  state_d = S_JR;
                            default:                                state_d = S_ILLEGAL;
                        endcase
                    end
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
                    OP_LW, OP_SW:     state_d = S_MADDR;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_ILLEGAL;
                endcase
            end
            S_MADDR: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                alu_ctrl_c  = ALU_ADD;
                state_d     = (bus.opcode == OP_LW) ? S_MREAD : S_MWRITE;
            end
            S_MREAD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (bus.mem_ready) state_d = S_MWB;
            end
            S_MWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 2'b01;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MWRITE: begin
                mem_write_c  = 1'b1;
                iord_c       = 1'b1;
                instr_done_c = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_REXEC: begin
                alu_src_a_c = (bus.funct == FN_SLL) ? 2'b10 : 2'b01;
                case (bus.funct)
                    FN_ADD:  alu_ctrl_c = ALU_ADD;
                    FN_SLT:  alu_ctrl_c = ALU_SLT;
                    FN_AND:  alu_ctrl_c = ALU_AND;
                    FN_NOR:  alu_ctrl_c = ALU_NOR;
                    FN_SLL:  alu_ctrl_c = ALU_SLL;
                    default: alu_ctrl_c = ALU_ADD;
                endcase
                state_d = S_RWB;
            end
            S_RWB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b01;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c  = 2'b01;
                alu_ctrl_c   = ALU_SUB;
                pc_source_c  = 2'b01;
                pc_en_c      = bus.zero;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from fetch, so it is the link value
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b10;
                mem_to_reg_c = 2'b10;
                pc_en_c      = 1'b1;
                pc_source_c  = 2'b10;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                imm_zext_c  = (bus.opcode == OP_ANDI);
                alu_ctrl_c  = (bus.opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
                state_d     = S_IWB;
            end
            S_IWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_JR: begin
                pc_en_c      = 1'b1;
                pc_source_c  = 2'b11;
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                state_d   = S_ILLEGAL;
            end
            default: begin
                state_d = S_ILLEGAL;
            end
        endcase
    end

    // Reset suppresses every enable so an aborted instruction commits nothing
    assign bus.pc_en      = pc_en_c      & ~reset;
    assign bus.ir_write   = ir_write_c   & ~reset;
    assign bus.reg_write  = reg_write_c  & ~reset;
    assign bus.mem_read   = mem_read_c   & ~reset;
    assign bus.mem_write  = mem_write_c  & ~reset;
    assign bus.instr_done = instr_done_c & ~reset;
    assign bus.illegal    = illegal_c    & ~reset;
    assign bus.iord       = iord_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.imm_zext   = imm_zext_c;
    assign bus.alu_ctrl   = alu_ctrl_c;
    assign bus.pc_source  = pc_source_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - directed vector bench for mips_multicycle_control
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b, imm_zext, alu_ctrl, pc_source, instr_done, illegal}
    function automatic logic [26:0] pk(
        input logic [3:0] st, input logic pe, input logic io, input logic mr,
        input logic mw, input logic irw, input logic [1:0] rd, input logic [1:0] m2r,
        input logic rw, input logic [1:0] sa, input logic [1:0] sb, input logic zx,
        input logic [3:0] ac, input logic [1:0] ps, input logic dn, input logic il);
        return {st, pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, zx, ac, ps, dn, il};
    endfunction

    function automatic void v(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic rdy, input logic [26:0] exp);
        vec_t t;
        t.rst = rst; t.op = op; t.fn = fn; t.z = z; t.rdy = rdy; t.exp = exp;
        vecs.push_back(t);
    endfunction

    function automatic logic [26:0] actual();
        return {bus.state, bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.imm_zext, bus.alu_ctrl, bus.pc_source, bus.instr_done, bus.illegal};
    endfunction

    task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy);
        reset         = rst;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    // Run one instruction from FETCH with mem_ready high and count cycles to instr_done
    task automatic count_cycles(input string name, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input int exp_n);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        drive(1'b0, op, fn, z, 1'b1);
        for (int k = 0; k < 20; k++) begin
            #1;
            n++;
            if (bus.instr_done) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        n_checks++;
        if (!seen || n != exp_n) begin
            n_fail++;
            $display("FAIL cycles_%s: got %0d cycles (done seen=%0d), expected %0d", name, n, seen, exp_n);
        end
        n_checks++;
        if (bus.state != 4'd0) begin
            n_fail++;
            $display("FAIL back_to_fetch_%s: state %0d, expected 0", name, bus.state);
        end
    endtask

    logic [26:0] F1, F0, DEC, MADDR, MREAD, MWB, MWW, MWR, RXADD, RXSLT, RXAND, RXNOR, RXSLL;
    logic [26:0] RWB, BRZ1, BRZ0, JAL, IXADDI, IXANDI, IWB, JR, ILL, RF, RILL, RMW;

    initial begin
        F1     = pk(0, 1,0,1,0,1, 0,0,0, 0,1,0, 4'b0010, 0, 0,0);
        F0     = pk(0, 0,0,1,0,0, 0,0,0, 0,1,0, 4'b0010, 0, 0,0);
        DEC    = pk(1, 0,0,0,0,0, 0,0,0, 0,3,0, 4'b0010, 0, 0,0);
        MADDR  = pk(2, 0,0,0,0,0, 0,0,0, 1,2,0, 4'b0010, 0, 0,0);
        MREAD  = pk(3, 0,1,1,0,0, 0,0,0, 0,0,0, 4'b0000, 0, 0,0);
        MWB    = pk(4, 0,0,0,0,0, 0,1,1, 0,0,0, 4'b0000, 0, 1,0);
        MWW    = pk(5, 0,1,0,1,0, 0,0,0, 0,0,0, 4'b0000, 0, 0,0);
        MWR    = pk(5, 0,1,0,1,0, 0,0,0, 0,0,0, 4'b0000, 0, 1,0);
        RXADD  = pk(6, 0,0,0,0,0, 0,0,0, 1,0,0, 4'b0010, 0, 0,0);
        RXSLT  = pk(6, 0,0,0,0,0, 0,0,0, 1,0,0, 4'b0111, 0, 0,0);
        RXAND  = pk(6, 0,0,0,0,0, 0,0,0, 1,0,0, 4'b0000, 0, 0,0);
        RXNOR  = pk(6, 0,0,0,0,0, 0,0,0, 1,0,0, 4'b1100, 0, 0,0);
        RXSLL  = pk(6, 0,0,0,0,0, 0,0,0, 2,0,0, 4'b1000, 0, 0,0);
        RWB    = pk(7, 0,0,0,0,0, 1,0,1, 0,0,0, 4'b0000, 0, 1,0);
        BRZ1   = pk(8, 1,0,0,0,0, 0,0,0, 1,0,0, 4'b0110, 1, 1,0);
        BRZ0   = pk(8, 0,0,0,0,0, 0,0,0, 1,0,0, 4'b0110, 1, 1,0);
        JAL    = pk(9, 1,0,0,0,0, 2,2,1, 0,0,0, 4'b0000, 2, 1,0);
        IXADDI = pk(10,0,0,0,0,0, 0,0,0, 1,2,0, 4'b0010, 0, 0,0);
        IXANDI = pk(10,0,0,0,0,0, 0,0,0, 1,2,1, 4'b0000, 0, 0,0);
        IWB    = pk(11,0,0,0,0,0, 0,0,1, 0,0,0, 4'b0000, 0, 1,0);
        JR     = pk(12,1,0,0,0,0, 0,0,0, 0,0,0, 4'b0000, 3, 1,0);
        ILL    = pk(13,0,0,0,0,0, 0,0,0, 0,0,0, 4'b0000, 0, 0,1);
        RF     = pk(0, 0,0,0,0,0, 0,0,0, 0,1,0, 4'b0010, 0, 0,0);
        RILL   = pk(13,0,0,0,0,0, 0,0,0, 0,0,0, 4'b0000, 0, 0,0);
        RMW    = pk(5, 0,1,0,0,0, 0,0,0, 0,0,0, 4'b0000, 0, 0,0);

        // reset state
        v(1, 0, 6'h20, 0, 1, RF);
        // add
        v(0, 0, 6'h20, 0, 1, F1); v(0, 0, 6'h20, 0, 1, DEC); v(0, 0, 6'h20, 0, 1, RXADD); v(0, 0, 6'h20, 0, 1, RWB);
        // lw: 2 stall cycles in FETCH, 1 in MREAD
        v(0, 35, 0, 0, 0, F0); v(0, 35, 0, 0, 0, F0); v(0, 35, 0, 0, 1, F1); v(0, 35, 0, 0, 1, DEC);
        v(0, 35, 0, 0, 1, MADDR); v(0, 35, 0, 0, 0, MREAD); v(0, 35, 0, 0, 1, MREAD); v(0, 35, 0, 0, 1, MWB);
        // beq taken / not taken
        v(0, 4, 0, 1, 1, F1); v(0, 4, 0, 1, 1, DEC); v(0, 4, 0, 1, 1, BRZ1);
        v(0, 4, 0, 0, 1, F1); v(0, 4, 0, 0, 1, DEC); v(0, 4, 0, 0, 1, BRZ0);
        // jal, jr
        v(0, 3, 0, 0, 1, F1); v(0, 3, 0, 0, 1, DEC); v(0, 3, 0, 0, 1, JAL);
        v(0, 0, 6'h08, 0, 1, F1); v(0, 0, 6'h08, 0, 1, DEC); v(0, 0, 6'h08, 0, 1, JR);
        // andi, addi
        v(0, 12, 0, 0, 1, F1); v(0, 12, 0, 0, 1, DEC); v(0, 12, 0, 0, 1, IXANDI); v(0, 12, 0, 0, 1, IWB);
        v(0, 8, 0, 0, 1, F1); v(0, 8, 0, 0, 1, DEC); v(0, 8, 0, 0, 1, IXADDI); v(0, 8, 0, 0, 1, IWB);
        // sll, slt, and, nor
        v(0, 0, 6'h00, 0, 1, F1); v(0, 0, 6'h00, 0, 1, DEC); v(0, 0, 6'h00, 0, 1, RXSLL); v(0, 0, 6'h00, 0, 1, RWB);
        v(0, 0, 6'h2a, 0, 1, F1); v(0, 0, 6'h2a, 0, 1, DEC); v(0, 0, 6'h2a, 0, 1, RXSLT); v(0, 0, 6'h2a, 0, 1, RWB);
        v(0, 0, 6'h24, 0, 1, F1); v(0, 0, 6'h24, 0, 1, DEC); v(0, 0, 6'h24, 0, 1, RXAND); v(0, 0, 6'h24, 0, 1, RWB);
        v(0, 0, 6'h27, 0, 1, F1); v(0, 0, 6'h27, 0, 1, DEC); v(0, 0, 6'h27, 0, 1, RXNOR); v(0, 0, 6'h27, 0, 1, RWB);
        // sw with one wait cycle in MWRITE
        v(0, 43, 0, 0, 1, F1); v(0, 43, 0, 0, 1, DEC); v(0, 43, 0, 0, 1, MADDR);
        v(0, 43, 0, 0, 0, MWW); v(0, 43, 0, 0, 1, MWR);
        // illegal opcode 2, held for 10 cycles
        v(0, 2, 0, 0, 1, F1); v(0, 2, 0, 0, 1, DEC);
        for (int k = 0; k < 10; k++) v(0, 2, 0, k[0], k[1], ILL);
        v(1, 2, 0, 0, 1, RILL);
        // illegal funct 000010 with opcode 0
        v(0, 0, 6'h02, 0, 1, F1); v(0, 0, 6'h02, 0, 1, DEC);
        v(0, 0, 6'h02, 0, 1, ILL); v(0, 0, 6'h02, 0, 1, ILL); v(0, 0, 6'h02, 0, 1, ILL);
        v(1, 0, 6'h02, 0, 1, RILL);
        // reset in MWRITE aborts the store
        v(0, 43, 0, 0, 1, F1); v(0, 43, 0, 0, 1, DEC); v(0, 43, 0, 0, 1, MADDR);
        v(1, 43, 0, 0, 1, RMW);
        v(0, 0, 6'h20, 0, 0, F0);

        drive(1'b1, 6'd0, 6'd0, 1'b0, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
            #2;
            n_checks++;
            if (actual() !== vecs[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d: got %07h (state %0d), expected %07h (state %0d)",
                         i, actual(), bus.state, vecs[i].exp, vecs[i].exp[26:23]);
            end
            n_checks++;
            if (bus.mem_read && bus.mem_write) begin
                n_fail++;
                $display("FAIL rw_exclusive vec%0d: mem_read=%0b mem_write=%0b, expected not both",
                         i, bus.mem_read, bus.mem_write);
            end
            @(posedge clk); #1;
        end

        // Fetch stall above left the FSM in FETCH; measure nominal instruction lengths
        count_cycles("beq", 6'd4,  6'd0,  1'b1, 3);
        count_cycles("jal", 6'd3,  6'd0,  1'b0, 3);
        count_cycles("jr",  6'd0,  6'h08, 1'b0, 3);
        count_cycles("add", 6'd0,  6'h20, 1'b0, 4);
        count_cycles("addi",6'd8,  6'd0,  1'b0, 4);
        count_cycles("sw",  6'd43, 6'd0,  1'b0, 4);
        count_cycles("lw",  6'd35, 6'd0,  1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
